spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
- Shares one SPIMaster instance (26-bit word, request/response enq handshakes) between NREQ client requesters.
- Each client has a one-entry request holding register. A round-robin scheduler issues one SPI transaction at a time and tracks the owner. The response is routed back to that owner only.
- Optional response timeout protects clients against a hung transfer.
- Sits between client logic and the SPIMaster instance; instantiated in the SPI top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 26, SPI word width; must match the SPIMaster width.
- TIMEOUT, 1024, cycles to wait for spi response before error-completing; 0 disables.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- req_enq__ENA  input  NREQ  per-client request strobe.
- req_enq__RDY  output  NREQ  per-client ready.
- req_data  input  NREQ*WIDTH  client i word at bits [i*WIDTH +: WIDTH].
- spi_req_enq__ENA  output  1  request strobe to SPIMaster.
- spi_req_enq__RDY  input  1  SPIMaster request ready.
- spi_req_data  output  WIDTH  word to SPIMaster.
- spi_rsp_enq__ENA  input  1  response strobe from SPIMaster.
- spi_rsp_enq__RDY  output  1  response ready to SPIMaster.
- spi_rsp_data  input  WIDTH  response word.
- rsp_enq__ENA  output  NREQ  per-client response strobe (one-hot or zero).
- rsp_enq__RDY  input  NREQ  per-client response ready.
- rsp_data  output  WIDTH  response word, shared by all clients.
- rsp_err  output  1  valid with rsp_enq__ENA; 1 = timed out, data is 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, nRST=0):
  - valid[] = 0; state = IDLE; ptr = 0; owner = 0; timer = 0; rsp_reg = 0; err_reg = 0.
  - All ENA outputs are 0 and busy = 0. req_enq__RDY is all ones once nRST=1.
- Holding registers:
  - req_enq__RDY[i] = !valid[i], a registered value. RDY never depends on ENA.
  - On ENA[i] && RDY[i], latch the word into hold[i] and set valid[i]. The entry is visible to the scheduler next cycle.
- State machine, one transaction at a time:
  - IDLE: if any valid, grant the first valid index searching ptr, ptr+1, … mod NREQ. Set owner = grant, go to ISSUE. Minimum latency: client enq at cycle 0, grant at cycle 1, spi_req ENA at cycle 2.
  - ISSUE: spi_req_enq__ENA = spi_req_enq__RDY; spi_req_data = hold[owner]. On fire, clear valid[owner], load timer = 0, go to WAIT. req_enq__RDY[owner] rises the next cycle.
  - WAIT: spi_rsp_enq__RDY = 1. On spi_rsp_enq__ENA, capture data into rsp_reg, set err_reg = 0, go to DELIVER. Otherwise timer++. If TIMEOUT != 0 and timer == TIMEOUT-1, set rsp_reg = 0, err_reg = 1, go to DELIVER.
  - DELIVER: rsp_enq__ENA[owner] = rsp_enq__RDY[owner]; rsp_data = rsp_reg; rsp_err = err_reg. On fire, ptr = (owner+1) mod NREQ, go to IDLE. Back-to-back transactions therefore have one IDLE cycle between them.
- spi_rsp_enq__RDY = 0 outside WAIT. A late response after a timeout is not accepted until the next WAIT; that stale case is documented and unsupported.
- spi_req_enq__ENA = 0 outside ISSUE; spi_req_data = 0 outside ISSUE.
- A client may enq a new word while its previous transaction is in WAIT or DELIVER, because valid is already cleared. It is not re-granted until ptr passes it.
- Round-robin is fair: with all clients pending, each is served once per NREQ transactions.
- Reset mid-transaction: everything is cleared immediately. Pending words are lost and no response is delivered. The SPIMaster shares nRST.
- Width rules:
  - ptr and owner are clog2(NREQ) bits; wrap uses an explicit compare against NREQ-1.
  - timer is clog2(TIMEOUT+1) bits and saturates (never wraps) when TIMEOUT=0.

Decomposition:
- Shared package spi_arb_pkg: state enum (IDLE, ISSUE, WAIT, DELIVER) and the default WIDTH constant 26.
- One sub-module, rr_pick: combinational round-robin priority encoder (valid vector and ptr in, grant index and any out).

Test Plan:
- Single client: client 2 enqs 26'h155_5555; SPIMaster returns 26'h0AB_CDEF.
  - Required: spi_req ENA at cycle 2 with data 26'h155_5555.
  - Required: rsp_enq__ENA = 4'b0100, rsp_data = 26'h0AB_CDEF, rsp_err = 0.
- All four clients enq in the same cycle, ptr = 0 → spi_req order is 0, 1, 2, 3. Each response goes only to the matching client.
- Client 1 re-enqs continuously while client 3 is pending → order alternates 1, 3, 1, 3; no starvation.
- spi_req RDY held low for 5 cycles in ISSUE → ENA stays 0 and hold data is unchanged. Issue occurs on the first RDY cycle.
- TIMEOUT = 8 with no spi response → DELIVER after 8 WAIT cycles; rsp_err = 1, rsp_data = 0; next client is served.
- nRST pulsed low during WAIT with clients 0 and 3 pending → all outputs are 0 immediately. req RDY returns to 4'b1111, busy = 0, and no response is delivered.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter.
//   arb_state_e : transaction state of the arbiter FSM
//   ARB_WIDTH   : default SPI word width (matches the SPIMaster instance)
package spi_arb_pkg;

   localparam int ARB_WIDTH = 26;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      DELIVER = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   valid_i : per-requester pending flags
//   ptr_i   : index with highest priority this round
//   grant_o : first pending index found searching ptr, ptr+1, ... mod NREQ
//   any_o   : at least one requester pending (grant_o is 0 otherwise)
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [PW-1:0]   grant_o,
   output logic            any_o
);

   int idx;

   // Scan from the lowest priority offset upward so the offset closest to
   // ptr_i is written last and wins.
   always_comb begin
      grant_o = '0;
      any_o   = |valid_i;
      idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (valid_i[idx]) grant_o = PW'(idx);
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPIMaster between NREQ clients. Each client owns a one-entry
// holding register; a round-robin scheduler issues one SPI transaction at a
// time and routes the response back to its owner only. An optional timeout
// error-completes a transfer whose response never arrives.
//
// Ports:
//   CLK, nRST                    clock, async active-low reset
//   req_enq__ENA/RDY, req_data   per-client request enq (word i at [i*WIDTH +: WIDTH])
//   spi_req_enq__ENA/RDY, _data  request to SPIMaster
//   spi_rsp_enq__ENA/RDY, _data  response from SPIMaster
//   rsp_enq__ENA/RDY             per-client response enq (ENA one-hot or zero)
//   rsp_data, rsp_err            shared response word; err = timed out, data 0
//   busy                         a transaction is in flight
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; grant next pending client round-robin
// ISSUE   | present hold[owner] to SPIMaster until accepted
// WAIT    | waiting for the SPI response, timer running
// DELIVER | present response/error to owner until accepted
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = ARB_WIDTH,
   parameter int TIMEOUT = 1024
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [NREQ-1:0]       req_enq__ENA,
   output logic [NREQ-1:0]       req_enq__RDY,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic                  spi_req_enq__ENA,
   input  logic                  spi_req_enq__RDY,
   output logic [WIDTH-1:0]      spi_req_data,
   input  logic                  spi_rsp_enq__ENA,
   output logic                  spi_rsp_enq__RDY,
   input  logic [WIDTH-1:0]      spi_rsp_data,
   output logic [NREQ-1:0]       rsp_enq__ENA,
   input  logic [NREQ-1:0]       rsp_enq__RDY,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int PW = $clog2(NREQ);
   // With the timeout disabled the timer only needs to exist; one bit that
   // saturates is enough.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  valid_q, valid_d;
   logic [WIDTH-1:0] hold_q [NREQ];
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] rsp_q, rsp_d;
   logic             err_q, err_d;

   logic [NREQ-1:0]  req_fire;
   logic [PW-1:0]    grant;
   logic             any;

   assign req_enq__RDY = ~valid_q;
   assign req_fire     = req_enq__ENA & ~valid_q;
   assign busy         = (state_q != IDLE);

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid_i (valid_q),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .any_o   (any)
   );

   always_comb begin
      state_d          = state_q;
      valid_d          = valid_q | req_fire;
      ptr_d            = ptr_q;
      owner_d          = owner_q;
      timer_d          = timer_q;
      rsp_d            = rsp_q;
      err_d            = err_q;
      spi_req_enq__ENA = 1'b0;
      spi_req_data     = '0;
      spi_rsp_enq__RDY = 1'b0;
      rsp_enq__ENA     = '0;
      rsp_data         = '0;
      rsp_err          = 1'b0;

      case (state_q)
         IDLE: begin
            if (any) begin
               owner_d = grant;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            spi_req_enq__ENA = spi_req_enq__RDY;
            spi_req_data     = hold_q[owner_q];
            if (spi_req_enq__RDY) begin
               // Owner's entry cannot be refilled this cycle (its RDY is 0),
               // so clearing after the OR above is safe.
               valid_d[owner_q] = 1'b0;
               timer_d          = '0;
               state_d          = WAIT;
            end
         end
         WAIT: begin
            spi_rsp_enq__RDY = 1'b1;
            if (spi_rsp_enq__ENA) begin
               rsp_d   = spi_rsp_data;
               err_d   = 1'b0;
               state_d = DELIVER;
            end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) begin
               rsp_d   = '0;
               err_d   = 1'b1;
               state_d = DELIVER;
            end else if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
         end
         DELIVER: begin
            rsp_enq__ENA[owner_q] = rsp_enq__RDY[owner_q];
            rsp_data              = rsp_q;
            rsp_err               = err_q;
            if (rsp_enq__RDY[owner_q]) begin
               ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         valid_q <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         timer_q <= '0;
         rsp_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         timer_q <= timer_d;
         rsp_q   <= rsp_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NREQ; i++) hold_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_fire[i]) hold_q[i] <= req_data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter (NREQ=4, WIDTH=26, TIMEOUT=8). The bench
// plays the SPIMaster and all four clients; responses are always accepted.
module tb_spi_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 26;
   localparam int TIMEOUT = 8;

   logic                  CLK = 1'b0;
   logic                  nRST;
   logic [NREQ-1:0]       req_enq__ENA;
   logic [NREQ-1:0]       req_enq__RDY;
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  spi_req_enq__ENA;
   logic                  spi_req_enq__RDY;
   logic [WIDTH-1:0]      spi_req_data;
   logic                  spi_rsp_enq__ENA;
   logic                  spi_rsp_enq__RDY;
   logic [WIDTH-1:0]      spi_rsp_data;
   logic [NREQ-1:0]       rsp_enq__ENA;
   logic [NREQ-1:0]       rsp_enq__RDY;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  busy;

   always #5 CLK = ~CLK;

   spi_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .CLK              (CLK),
      .nRST             (nRST),
      .req_enq__ENA     (req_enq__ENA),
      .req_enq__RDY     (req_enq__RDY),
      .req_data         (req_data),
      .spi_req_enq__ENA (spi_req_enq__ENA),
      .spi_req_enq__RDY (spi_req_enq__RDY),
      .spi_req_data     (spi_req_data),
      .spi_rsp_enq__ENA (spi_rsp_enq__ENA),
      .spi_rsp_enq__RDY (spi_rsp_enq__RDY),
      .spi_rsp_data     (spi_rsp_data),
      .rsp_enq__ENA     (rsp_enq__ENA),
      .rsp_enq__RDY     (rsp_enq__RDY),
      .rsp_data         (rsp_data),
      .rsp_err          (rsp_err),
      .busy             (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Land 1 time unit after the active edge; callers drive inputs there and
   // wait #1 more before sampling.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_word(input int i, input logic [WIDTH-1:0] w);
      req_data[i*WIDTH +: WIDTH] = w;
   endtask

   // Act as SPIMaster for one transaction: wait for the issue, check the word,
   // answer on the first WAIT cycle, then check delivery to the owner.
   task automatic serve(input string tag, input logic [NREQ-1:0] exp_oh,
                        input logic [WIDTH-1:0] exp_req, input logic [WIDTH-1:0] rsp_word);
      int n;
      n = 0;
      while (spi_req_enq__ENA !== 1'b1 && n < 20) begin
         tick(); #1;
         n++;
      end
      chk({tag, ".req_ena"}, 64'(spi_req_enq__ENA), 64'd1);
      chk({tag, ".req_data"}, 64'(spi_req_data), 64'(exp_req));
      tick();
      spi_rsp_enq__ENA = 1'b1;
      spi_rsp_data     = rsp_word;
      #1;
      chk({tag, ".rsp_rdy"}, 64'(spi_rsp_enq__RDY), 64'd1);
      tick();
      spi_rsp_enq__ENA = 1'b0;
      spi_rsp_data     = '0;
      #1;
      chk({tag, ".rsp_ena"}, 64'(rsp_enq__ENA), 64'(exp_oh));
      chk({tag, ".rsp_data"}, 64'(rsp_data), 64'(rsp_word));
      chk({tag, ".rsp_err"}, 64'(rsp_err), 64'd0);
      tick(); #1;
   endtask

   task automatic apply_reset(input string tag);
      nRST = 1'b0;
      #1;
      chk({tag, ".spi_req_ena"}, 64'(spi_req_enq__ENA), 64'd0);
      chk({tag, ".spi_rsp_rdy"}, 64'(spi_rsp_enq__RDY), 64'd0);
      chk({tag, ".rsp_ena"}, 64'(rsp_enq__ENA), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      tick(); tick();
      nRST = 1'b1;
      #1;
      chk({tag, ".req_rdy"}, 64'(req_enq__RDY), 64'hF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] w2 [NREQ];
      logic [NREQ-1:0]  oh;
      logic             seen;
      int               n_wait;
      int               n;

      nRST             = 1'b1;
      req_enq__ENA     = '0;
      req_data         = '0;
      spi_req_enq__RDY = 1'b1;
      spi_rsp_enq__ENA = 1'b0;
      spi_rsp_data     = '0;
      rsp_enq__RDY     = '1;
      #2;
      apply_reset("rst0");

      // Single client: enq at cycle 0, issue at cycle 2, response to client 2.
      req_enq__ENA = 4'b0100;
      set_word(2, 26'h155_5555);
      #1;
      tick();
      req_enq__ENA = '0;
      #1;
      chk("t1.c1_req_rdy", 64'(req_enq__RDY), 64'b1011);
      chk("t1.c1_spi_ena", 64'(spi_req_enq__ENA), 64'd0);
      tick(); #1;
      chk("t1.c2_spi_ena", 64'(spi_req_enq__ENA), 64'd1);
      chk("t1.c2_spi_data", 64'(spi_req_data), 64'h155_5555);
      chk("t1.c2_busy", 64'(busy), 64'd1);
      tick();
      spi_rsp_enq__ENA = 1'b1;
      spi_rsp_data     = 26'h0AB_CDEF;
      #1;
      chk("t1.c3_req_rdy", 64'(req_enq__RDY), 64'hF);
      chk("t1.c3_spi_rsp_rdy", 64'(spi_rsp_enq__RDY), 64'd1);
      tick();
      spi_rsp_enq__ENA = 1'b0;
      spi_rsp_data     = '0;
      #1;
      chk("t1.rsp_ena", 64'(rsp_enq__ENA), 64'b0100);
      chk("t1.rsp_data", 64'(rsp_data), 64'h0AB_CDEF);
      chk("t1.rsp_err", 64'(rsp_err), 64'd0);
      tick(); #1;
      chk("t1.idle_busy", 64'(busy), 64'd0);

      // All four at once from ptr = 0: served 0, 1, 2, 3.
      apply_reset("rst1");
      for (int i = 0; i < NREQ; i++) begin
         w2[i] = 26'h0C0_0000 + WIDTH'(i);
         set_word(i, w2[i]);
      end
      req_enq__ENA = 4'b1111;
      #1;
      tick();
      req_enq__ENA = '0;
      #1;
      for (int i = 0; i < NREQ; i++) begin
         oh = 4'b0001 << i;
         serve($sformatf("t2.c%0d", i), oh, w2[i], 26'h3A5_0000 + WIDTH'(i));
      end

      // Clients 1 and 3 keep re-enqueuing: service alternates 1, 3, 1, 3, ...
      set_word(1, 26'h111_1111);
      set_word(3, 26'h333_3333);
      req_enq__ENA = 4'b1010;
      #1;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) req_enq__ENA = '0;
         if ((k % 2) == 0)
            serve($sformatf("t3.k%0d", k), 4'b0010, 26'h111_1111, 26'h200_0000 + WIDTH'(k));
         else
            serve($sformatf("t3.k%0d", k), 4'b1000, 26'h333_3333, 26'h200_0000 + WIDTH'(k));
      end

      // SPIMaster stalls 5 cycles in ISSUE; hold word must survive a re-enq try.
      spi_req_enq__RDY = 1'b0;
      set_word(0, 26'h0F0_F0F0);
      req_enq__ENA = 4'b0001;
      #1;
      tick();
      set_word(0, 26'h3FF_FFFF);
      #1;
      tick(); #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4.stall%0d_ena", k), 64'(spi_req_enq__ENA), 64'd0);
         chk($sformatf("t4.stall%0d_data", k), 64'(spi_req_data), 64'h0F0_F0F0);
         tick(); #1;
      end
      chk("t4.req_rdy0", 64'(req_enq__RDY), 64'b1110);
      req_enq__ENA     = '0;
      spi_req_enq__RDY = 1'b1;
      #1;
      serve("t4.go", 4'b0001, 26'h0F0_F0F0, 26'h123_4567);

      // Timeout: client 2 gets no response, client 3 is served afterwards.
      set_word(2, 26'h022_2222);
      set_word(3, 26'h033_3333);
      req_enq__ENA = 4'b1100;
      #1;
      tick();
      req_enq__ENA = '0;
      #1;
      n = 0;
      while (spi_req_enq__ENA !== 1'b1 && n < 20) begin
         tick(); #1;
         n++;
      end
      chk("t5.req_data", 64'(spi_req_data), 64'h022_2222);
      tick(); #1;
      n_wait = 0;
      while (spi_rsp_enq__RDY === 1'b1 && n_wait < 20) begin
         n_wait++;
         tick(); #1;
      end
      chk("t5.wait_cycles", 64'(n_wait), 64'd8);
      chk("t5.rsp_ena", 64'(rsp_enq__ENA), 64'b0100);
      chk("t5.rsp_err", 64'(rsp_err), 64'd1);
      chk("t5.rsp_data", 64'(rsp_data), 64'd0);
      tick(); #1;
      serve("t5.next", 4'b1000, 26'h033_3333, 26'h0DE_AD00);

      // Reset while in WAIT with clients 0 and 3 pending.
      set_word(0, 26'h000_0AAA);
      set_word(3, 26'h000_0BBB);
      req_enq__ENA = 4'b1001;
      #1;
      tick();
      req_enq__ENA = '0;
      #1;
      n = 0;
      while (spi_req_enq__ENA !== 1'b1 && n < 20) begin
         tick(); #1;
         n++;
      end
      tick(); #1;
      chk("t6.in_wait", 64'(spi_rsp_enq__RDY), 64'd1);
      apply_reset("t6.rst");
      chk("t6.busy", 64'(busy), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(); #1;
         if (rsp_enq__ENA != '0 || spi_req_enq__ENA || busy) seen = 1'b1;
      end
      chk("t6.quiet_after_reset", 64'(seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
